// File: rtl/gray_bcd_pkg.sv
// Shared types and the Gray-to-BCD decode table for the gray_bcd_decoder slice.
package gray_bcd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef struct packed {
    logic       err;
    logic       step;
    logic [3:0] bcd;
  } entry_t;

  // Returns {err, bcd}; the six codes outside the decade map to BCD_INVALID.
  function automatic logic [4:0] gray_to_bcd(input logic [3:0] g);
    logic [4:0] r;
    case (g)
      4'd0:    r = {1'b0, 4'd0};
      4'd1:    r = {1'b0, 4'd1};
      4'd3:    r = {1'b0, 4'd2};
      4'd2:    r = {1'b0, 4'd3};
      4'd6:    r = {1'b0, 4'd4};
      4'd7:    r = {1'b0, 4'd5};
      4'd5:    r = {1'b0, 4'd6};
      4'd4:    r = {1'b0, 4'd7};
      4'd12:   r = {1'b0, 4'd8};
      4'd13:   r = {1'b0, 4'd9};
      default: r = {1'b1, BCD_INVALID};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gray_bcd_lut.sv
// Combinational Gray -> {err, bcd} decode on the input side of the buffer.
module gray_bcd_lut
  import gray_bcd_pkg::*;
(
  input  logic [3:0] gray,
  output logic       err,
  output logic [3:0] bcd
);

  assign {err, bcd} = gray_to_bcd(gray);

endmodule

// File: rtl/gray_bcd_decoder.sv
// Streaming Gray-to-BCD decoder with a 2-entry valid/ready buffer and error counter.
// Optional decade-sequence checking is enabled by defining GRAY_STEP_CHECK_EN.
module gray_bcd_decoder
  import gray_bcd_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           bcd,
  output logic                 out_err,
  output logic                 step_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  buf_state_t state, state_next;
  entry_t     head, tail, new_entry;
  logic       dec_err;
  logic [3:0] dec_bcd;
  logic       new_step;
  logic       push, pop;

  gray_bcd_lut u_lut (
    .gray (gray),
    .err  (dec_err),
    .bcd  (dec_bcd)
  );

  // rst_n gating keeps in_ready low for the whole reset window.
  assign in_ready  = rst_n && en && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef GRAY_STEP_CHECK_EN
  logic       hist_valid;
  logic [3:0] hist_digit;
  logic [3:0] next_digit;

  assign next_digit = (hist_digit == 4'd9) ? 4'd0 : hist_digit + 4'd1;
  assign new_step   = !dec_err && hist_valid && (dec_bcd != next_digit);

  // An invalid code clears the history so the following digit reseeds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= 1'b0;
      hist_digit <= 4'd0;
    end else if (push) begin
      hist_valid <= !dec_err;
      hist_digit <= dec_bcd;
    end
  end
`else
  assign new_step = 1'b0;
`endif

  assign new_entry = '{err: dec_err, step: new_step, bcd: dec_bcd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // head is always the oldest entry; tail is only occupied in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head <= new_entry;
        ONE: begin
          if (push && pop) head <= new_entry;
          else if (push)   tail <= new_entry;
        end
        FULL:    if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (push && dec_err && (err_count != {ERR_CNT_W{1'b1}}))
      err_count <= err_count + ERR_CNT_W'(1);
  end

  assign bcd      = head.bcd;
  assign out_err  = head.err;
  assign step_err = head.step;

endmodule
